// File: rtl/instr_fetch_pkg.sv
// Shared fetch-side types and constants for the instruction fetch unit,
// decode and benches.
package instr_fetch_pkg;

   localparam int unsigned INSTR_BYTES      = 4;
   localparam int unsigned DEFAULT_RESET_PC = 0;
   localparam int unsigned ADDR_W           = 32;
   localparam int unsigned INSTR_W          = 32;

   // Primary opcode field values (instr[31:26]) used by decode and benches
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   // Instruction word handed to decode together with its fetch address
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_out_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch requester: holds the PC, waits for the ROM to settle,
// registers the word and offers it to decode over valid/ready.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned MEM_BYTES   = 32,
   parameter int unsigned RESET_PC    = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  read_address,
   input  logic [INSTR_W-1:0] instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               halted
);

   localparam int unsigned CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_BYTES);
   localparam logic [ADDR_W-1:0] PC_RESET   = ADDR_W'(RESET_PC) & ~ADDR_W'(3);
   localparam logic              RESET_HALT = (PC_RESET >= MEM_LIMIT);

   fetch_state_e      state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [ADDR_W-1:0] pc, pc_n;
   fetch_out_t        held, held_n;
   logic              valid_q, valid_n;
   logic              halted_q, halted_n;

   logic [ADDR_W-1:0] redirect_tgt;
   logic [ADDR_W-1:0] pc_inc;

   assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
   assign pc_inc       = pc + ADDR_W'(INSTR_BYTES);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RESET_HALT ? HALT : FETCH;
         cnt      <= CNT_INIT;
         pc       <= PC_RESET;
         held     <= '0;
         valid_q  <= 1'b0;
         halted_q <= RESET_HALT;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         pc       <= pc_n;
         held     <= held_n;
         valid_q  <= valid_n;
         halted_q <= halted_n;
      end
   end

   // Next-state, wait counter and next-PC selection; redirect wins over all
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      pc_n     = pc;
      held_n   = held;
      valid_n  = valid_q;
      halted_n = halted_q;

      if (redirect_valid) begin
         pc_n    = redirect_tgt;
         valid_n = 1'b0;
         cnt_n   = CNT_INIT;
         if (redirect_tgt >= MEM_LIMIT) begin
            state_n  = HALT;
            halted_n = 1'b1;
         end else begin
            state_n  = FETCH;
            halted_n = 1'b0;
         end
      end else begin
         case (state)
            FETCH: begin
               if (cnt == '0) begin
                  held_n.instr = instr;
                  held_n.pc    = pc;
                  valid_n      = 1'b1;
                  state_n      = VALID;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
            VALID: begin
               if (out_ready) begin
                  valid_n = 1'b0;
                  pc_n    = pc_inc;
                  if (pc_inc >= MEM_LIMIT) begin
                     state_n  = HALT;
                     halted_n = 1'b1;
                  end else begin
                     state_n = FETCH;
                     cnt_n   = CNT_INIT;
                  end
               end
            end
            HALT: begin
               valid_n = 1'b0;
            end
            default: begin
               state_n = FETCH;
               cnt_n   = CNT_INIT;
               valid_n = 1'b0;
            end
         endcase
      end
   end

   assign read_address = pc;
   assign out_valid    = valid_q;
   assign out_instr    = held.instr;
   assign out_pc       = held.pc;
   assign halted       = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a small combinational ROM model.
module tb_instr_fetch;

   localparam int unsigned WAIT = 3;
   localparam int unsigned MEM  = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] read_address;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;

   instr_fetch #(
      .WAIT_CYCLES(WAIT),
      .MEM_BYTES  (MEM),
      .RESET_PC   (0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .read_address  (read_address),
      .instr         (instr),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      case (addr)
         32'd0:   rom_word = 32'h20080005;
         32'd4:   rom_word = 32'h20090006;
         32'd8:   rom_word = 32'h28090001;
         32'd12:  rom_word = 32'h01095022;
         32'd16:  rom_word = 32'h3109000F;
         32'd20:  rom_word = 32'h35090008;
         32'd24:  rom_word = 32'h01095020;
         32'd28:  rom_word = 32'hAC0A0004;
         default: rom_word = 32'h00000000;
      endcase
   endfunction

   assign instr = rom_word(read_address);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until out_valid is seen; a timeout returns an out-of-range count
   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!out_valid && cycles < 40);
   endtask

   task automatic do_redirect(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      tick();
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
   endtask

   task automatic expect_word(input string tag, input int exp_cycles,
                              input logic [31:0] exp_pc, input logic [31:0] exp_instr);
      wait_valid(cyc);
      check({tag, "_lat"}, 32'(cyc), 32'(exp_cycles));
      check({tag, "_pc"}, out_pc, exp_pc);
      check({tag, "_instr"}, out_instr, exp_instr);
   endtask

   initial begin
      rst_n          = 1'b0;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_addr", read_address, 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_pc", out_pc, 32'd0);
      #2 rst_n = 1'b1;

      // Streaming with continuous ready
      expect_word("w0", WAIT, 32'd0, 32'h20080005);
      expect_word("w4", WAIT + 1, 32'd4, 32'h20090006);
      expect_word("w8", WAIT + 1, 32'd8, 32'h28090001);
      expect_word("w12", WAIT + 1, 32'd12, 32'h01095022);
      expect_word("w16", WAIT + 1, 32'd16, 32'h3109000F);

      // Decode stall at pc=16
      out_ready = 1'b0;
      repeat (5) tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_instr", out_instr, 32'h3109000F);
      check("stall_addr", read_address, 32'd16);
      out_ready = 1'b1;
      expect_word("w20", WAIT + 1, 32'd20, 32'h35090008);
      expect_word("w24", WAIT + 1, 32'd24, 32'h01095020);
      expect_word("w28", WAIT + 1, 32'd28, 32'hAC0A0004);

      // Accepting the last word halts fetch
      tick();
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_valid", 32'(out_valid), 32'd0);
      repeat (6) tick();
      check("halt_hold_valid", 32'(out_valid), 32'd0);
      check("halt_hold_addr", read_address, 32'd32);

      // Redirect out of HALT
      do_redirect(32'd0);
      check("unhalt_flag", 32'(halted), 32'd0);
      expect_word("re0", WAIT, 32'd0, 32'h20080005);

      // Redirect while fetching pc=4; low bits of the target are dropped
      tick();
      check("f4_addr", read_address, 32'd4);
      do_redirect(32'h1B);
      check("redir_addr", read_address, 32'd24);
      expect_word("re24", WAIT, 32'd24, 32'h01095020);

      // Redirect to 12 on the handshake of 24, then redirect on handshake at 12
      do_redirect(32'd12);
      expect_word("re12", WAIT, 32'd12, 32'h01095022);
      do_redirect(32'd20);
      check("hs_redir_valid", 32'(out_valid), 32'd0);
      check("hs_redir_addr", read_address, 32'd20);
      expect_word("re20", WAIT, 32'd20, 32'h35090008);

      // Async reset while holding pc=8
      out_ready = 1'b0;
      do_redirect(32'd8);
      expect_word("re8", WAIT, 32'd8, 32'h28090001);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_addr", read_address, 32'd0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      expect_word("post_rst", WAIT, 32'd0, 32'h20080005);

      // Redirect beyond program space halts immediately
      do_redirect(32'h23);
      check("oob_halted", 32'(halted), 32'd1);
      check("oob_addr", read_address, 32'd32);
      repeat (4) tick();
      check("oob_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
